// File: rtl/nes_bus_arb_pkg.sv
// Shared NES bus definitions: arbiter state encoding, CPU address map and
// arbitration mode selectors.
package nes_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALT = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    typedef enum logic [2:0] {
        RGN_RAM = 3'd0,
        RGN_PPU = 3'd1,
        RGN_APU = 3'd2,
        RGN_JPD = 3'd3,
        RGN_MMC = 3'd4
    } region_t;

    localparam logic [15:0] RAM_HI = 16'h1FFF;
    localparam logic [15:0] PPU_HI = 16'h3FFF;
    localparam logic [15:0] APU_LO = 16'h4000;
    localparam logic [15:0] JPD_LO = 16'h4016;
    localparam logic [15:0] JPD_HI = 16'h4017;
    localparam logic [15:0] MMC_LO = 16'h4020;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Joypad ports sit inside the APU window, so they are tested first.
    function automatic region_t addr_region(input logic [15:0] addr);
        if (addr <= RAM_HI)
            return RGN_RAM;
        else if (addr <= PPU_HI)
            return RGN_PPU;
        else if (addr >= JPD_LO && addr <= JPD_HI)
            return RGN_JPD;
        else if (addr >= APU_LO && addr < MMC_LO)
            return RGN_APU;
        else
            return RGN_MMC;
    endfunction

endpackage

// File: rtl/nes_bus_rr_pick.sv
// Combinational requestor picker: returns a one-hot winner, searching upward
// from the pointer and wrapping. A zero pointer gives fixed lowest-index priority.
module nes_bus_rr_pick
    import nes_bus_arb_pkg::*;
#(
    parameter int N_DMA = 2,
    parameter int PTR_W = (N_DMA > 1) ? $clog2(N_DMA) : 1
) (
    input  logic [N_DMA-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_DMA-1:0] gnt
);

    // Offsets are walked from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt = '0;
        for (int off = N_DMA - 1; off >= 0; off--) begin
            for (int k = 0; k < N_DMA; k++) begin
                if (req[k] && (k == (int'(ptr) + off) % N_DMA)) begin
                    gnt    = '0;
                    gnt[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nes_bus_arb.sv
// NES CPU/DMA bus arbiter: halts the CPU on a read cycle, grants the bus to one
// DMA requestor for a bounded burst, and decodes the shared slave read mux.
module nes_bus_arb
    import nes_bus_arb_pkg::*;
#(
    parameter int N_DMA     = 2,
    parameter int ARB_MODE  = 0,
    parameter int MAX_BURST = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_cpu_addr,
    input  logic                 i_cpu_r_wn,
    input  logic [7:0]           i_cpu_wdata,
    output logic [7:0]           o_cpu_rdata,
    output logic                 o_cpu_pause,
    input  logic [N_DMA-1:0]     i_dma_req,
    output logic [N_DMA-1:0]     o_dma_gnt,
    input  logic [16*N_DMA-1:0]  i_dma_addr,
    input  logic [N_DMA-1:0]     i_dma_r_wn,
    input  logic [8*N_DMA-1:0]   i_dma_wdata,
    output logic [7:0]           o_dma_rdata,
    output logic [N_DMA-1:0]     o_dma_rvalid,
    output logic [15:0]          o_bus_addr,
    output logic [7:0]           o_bus_wdata,
    output logic                 o_bus_r_wn,
    input  logic [7:0]           i_ram_rdata,
    input  logic [7:0]           i_ppu_rdata,
    input  logic [7:0]           i_apu_rdata,
    input  logic [7:0]           i_jpd_rdata,
    input  logic [7:0]           i_mmc_rdata
);

    localparam int         PTR_W     = (N_DMA > 1) ? $clog2(N_DMA) : 1;
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       beat_cnt;
    logic [7:0]       hold_rdata;
    logic [7:0]       bus_rdata;
    logic [N_DMA-1:0] pick_gnt;
    logic [N_DMA-1:0] owner_onehot;
    logic             owner_req;

    assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    nes_bus_rr_pick #(
        .N_DMA (N_DMA),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (i_dma_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_DMA; k++) begin
            if (pick_gnt[k])
                pick_idx = PTR_W'(k);
        end
    end

    assign next_ptr = (int'(pick_idx) == N_DMA - 1) ? '0 : pick_idx + 1'b1;

    always_comb begin
        owner_onehot = '0;
        for (int k = 0; k < N_DMA; k++) begin
            owner_onehot[k] = (int'(owner) == k);
        end
    end

    assign owner_req = |(i_dma_req & owner_onehot);

    // The owner's slice only reaches the bus while it actually holds the grant.
    always_comb begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wdata = i_cpu_wdata;
        o_bus_r_wn  = i_cpu_r_wn;
        if (state == ST_XFER) begin
            for (int k = 0; k < N_DMA; k++) begin
                if (owner_onehot[k]) begin
                    o_bus_addr  = i_dma_addr[16*k +: 16];
                    o_bus_wdata = i_dma_wdata[8*k +: 8];
                    o_bus_r_wn  = i_dma_r_wn[k];
                end
            end
        end
    end

    always_comb begin
        case (addr_region(o_bus_addr))
            RGN_RAM: bus_rdata = i_ram_rdata;
            RGN_PPU: bus_rdata = i_ppu_rdata;
            RGN_APU: bus_rdata = i_apu_rdata;
            RGN_JPD: bus_rdata = i_jpd_rdata;
            default: bus_rdata = i_mmc_rdata;
        endcase
    end

    assign o_dma_rdata  = bus_rdata;
    assign o_dma_gnt    = (state == ST_XFER) ? owner_onehot : '0;
    assign o_dma_rvalid = o_dma_gnt & i_dma_r_wn;
    assign o_cpu_pause  = (state != ST_IDLE);
    assign o_cpu_rdata  = (state == ST_IDLE) ? bus_rdata : hold_rdata;

    // A halt only starts on a CPU read cycle; every grant returns through IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            hold_rdata <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_rdata <= bus_rdata;
                    if (|i_dma_req && i_cpu_r_wn)
                        state <= ST_HALT;
                end
                ST_HALT: begin
                    if (|i_dma_req) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_XFER;
                        if (ARB_MODE == ARB_RR)
                            rr_ptr <= next_ptr;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (!owner_req || beat_cnt == LAST_BEAT)
                        state <= ST_IDLE;
                    else
                        beat_cnt <= beat_cnt + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
